// File: rtl/sr_pkg.sv
// Shared types and limits for the SR flip-flop bank.
package sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_RST_DOM = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  localparam int unsigned SR_N_MAX  = 32;
  localparam int unsigned SR_CW_MAX = 16;

endpackage

// File: rtl/sr_cell.sv
// One clocked SR channel: state, S=R=1 resolution, conflict pulse and the
// optional saturating conflict counter (SR_CONFLICT_CNT_EN).
module sr_cell
  import sr_pkg::*;
#(
  parameter sr_mode_e    MODE      = SR_HOLD,
  parameter logic        RESET_VAL = 1'b0,
  parameter int unsigned CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          s,
  input  logic          r,
`ifdef SR_CONFLICT_CNT_EN
  input  logic          cnt_clr,
  output logic [CW-1:0] conflict_cnt,
`endif
  output logic          q,
  output logic          conflict
);

  if (!(MODE inside {SR_HOLD, SR_SET_DOM, SR_RST_DOM, SR_TOGGLE})) begin : gen_bad_mode
    $error("sr_cell: illegal MODE");
  end

  logic q_d, q_q;
  logic conflict_d, conflict_q;

  assign conflict_d = en & s & r;

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case ({s, r})
        2'b00: q_d = q_q;
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          unique case (MODE)
            SR_HOLD:    q_d = q_q;
            SR_SET_DOM: q_d = 1'b1;
            SR_RST_DOM: q_d = 1'b0;
            SR_TOGGLE:  q_d = ~q_q;
            default:    q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= RESET_VAL;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign conflict = conflict_q;

`ifdef SR_CONFLICT_CNT_EN
  logic [CW-1:0] cnt_q;

  // Clear takes priority over a coincident conflict; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (conflict_d && (cnt_q != {CW{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N independent clocked SR flip-flops; conflict counters and the
// cnt_clr/conflict_cnt ports exist only with SR_CONFLICT_CNT_EN defined.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int unsigned   N         = 4,
  parameter sr_mode_e      MODE      = SR_HOLD,
  parameter logic [N-1:0]  RESET_VAL = '0,
  parameter int unsigned   CW        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    S,
  input  logic [N-1:0]    R,
`ifdef SR_CONFLICT_CNT_EN
  input  logic            cnt_clr,
  output logic [N*CW-1:0] conflict_cnt,
`endif
  output logic [N-1:0]    Q,
  output logic [N-1:0]    Qbar,
  output logic [N-1:0]    conflict
);

  if (N < 1 || N > SR_N_MAX) begin : gen_bad_n
    $error("sr_ff_bank: N out of range");
  end
  if (CW < 1 || CW > SR_CW_MAX) begin : gen_bad_cw
    $error("sr_ff_bank: CW out of range");
  end

  for (genvar i = 0; i < N; i++) begin : gen_cell
    sr_cell #(
      .MODE      (MODE),
      .RESET_VAL (RESET_VAL[i]),
      .CW        (CW)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s            (S[i]),
      .r            (R[i]),
`ifdef SR_CONFLICT_CNT_EN
      .cnt_clr      (cnt_clr),
      .conflict_cnt (conflict_cnt[i*CW +: CW]),
`endif
      .q            (Q[i]),
      .conflict     (conflict[i])
    );
  end

  // Qbar is never stored, so it cannot disagree with Q.
  assign Qbar = ~Q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: one instance per MODE sharing stimulus.
module tb_sr_ff_bank;
  import sr_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [N-1:0] S = '0;
  logic [N-1:0] R = '0;
  logic         cnt_clr = 1'b0;

  logic [N-1:0]    q_a    [4];
  logic [N-1:0]    qb_a   [4];
  logic [N-1:0]    cf_a   [4];
  logic [N*CW-1:0] cnt_a  [4];
  logic [N-1:0]    exp_q  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index 0..3 = SR_HOLD, SR_SET_DOM, SR_RST_DOM, SR_TOGGLE.
  for (genvar g = 0; g < 4; g++) begin : gen_dut
    sr_ff_bank #(
      .N         (N),
      .MODE      (sr_mode_e'(g)),
      .RESET_VAL (4'b1010),
      .CW        (CW)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .S            (S),
      .R            (R),
`ifdef SR_CONFLICT_CNT_EN
      .cnt_clr      (cnt_clr),
      .conflict_cnt (cnt_a[g]),
`endif
      .Q            (q_a[g]),
      .Qbar         (qb_a[g]),
      .conflict     (cf_a[g])
    );
`ifndef SR_CONFLICT_CNT_EN
    assign cnt_a[g] = '0;
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; S = 4'b0101; R = 4'b1010;
    step();
    S = 4'b1111; R = 4'b1111;
    step();
    // Mid-cycle async assert must act before the next edge.
    #2;
    rst = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (q_a[m] !== 4'b1010 || qb_a[m] !== 4'b0101) begin
        errors++;
        $display("FAIL reset_q mode%0d got Q=%b Qbar=%b want 1010/0101", m, q_a[m], qb_a[m]);
      end
      checks++;
      if (cf_a[m] !== 4'b0000 || cnt_a[m] !== '0) begin
        errors++;
        $display("FAIL reset_cf mode%0d got conflict=%b cnt=%h want 0/0", m, cf_a[m], cnt_a[m]);
      end
    end
    #1;
    rst = 1'b0;
    S = 4'b0001; R = 4'b0000;
    step();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (q_a[m] !== 4'b1011) begin
        errors++;
        $display("FAIL first_edge mode%0d got %b want 1011", m, q_a[m]);
      end
    end
  endtask

  task automatic test_basic();
    pulse_reset();
    en = 1'b1; S = 4'b0001; R = 4'b0000;
    step();
    checks++;
    if (q_a[0] !== 4'b1011 || qb_a[0] !== 4'b0100 || cf_a[0] !== 4'b0000) begin
      errors++;
      $display("FAIL basic_set got Q=%b Qbar=%b cf=%b want 1011/0100/0000",
               q_a[0], qb_a[0], cf_a[0]);
    end
    S = 4'b0000; R = 4'b0001;
    step();
    checks++;
    if (q_a[0] !== 4'b1010 || qb_a[0] !== 4'b0101) begin
      errors++;
      $display("FAIL basic_rst got Q=%b Qbar=%b want 1010/0101", q_a[0], qb_a[0]);
    end
  endtask

  task automatic test_modes();
    pulse_reset();
    en = 1'b1; S = 4'b0001; R = 4'b0001;
    exp_q[0] = 4'b1010; exp_q[1] = 4'b1011; exp_q[2] = 4'b1010; exp_q[3] = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_q[3] = exp_q[3] ^ 4'b0001;
      for (int m = 0; m < 4; m++) begin
        checks++;
        if (q_a[m] !== exp_q[m] || qb_a[m] !== ~exp_q[m] || cf_a[m] !== 4'b0001) begin
          errors++;
          $display("FAIL mode_sweep mode%0d edge%0d got Q=%b Qbar=%b cf=%b want %b/%b/0001",
                   m, k, q_a[m], qb_a[m], cf_a[m], exp_q[m], ~exp_q[m]);
        end
      end
    end
  endtask

  task automatic test_enable();
    // Continues from test_modes: toggle instance ends at 1011.
    en = 1'b0; S = 4'b1111; R = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      for (int m = 0; m < 4; m++) begin
        checks++;
        if (q_a[m] !== exp_q[m] || cf_a[m] !== 4'b0000) begin
          errors++;
          $display("FAIL enable_gate mode%0d edge%0d got Q=%b cf=%b want %b/0000",
                   m, k, q_a[m], cf_a[m], exp_q[m]);
        end
      end
    end
  endtask

  task automatic test_toggle_reset();
    pulse_reset();
    en = 1'b1; S = 4'b1111; R = 4'b1111;
    step();
    checks++;
    if (q_a[3] !== 4'b0101) begin
      errors++;
      $display("FAIL toggle_all got %b want 0101", q_a[3]);
    end
    pulse_reset();
    #1;
    checks++;
    if (q_a[3] !== 4'b1010 || cf_a[3] !== 4'b0000) begin
      errors++;
      $display("FAIL toggle_reset got Q=%b cf=%b want 1010/0000", q_a[3], cf_a[3]);
    end
  endtask

`ifdef SR_CONFLICT_CNT_EN
  task automatic test_counter();
    logic [CW-1:0] c2;
    logic [CW-1:0] want;
    pulse_reset();
    en = 1'b1; S = 4'b0100; R = 4'b0100; cnt_clr = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      c2   = cnt_a[0][2*CW +: CW];
      want = (k > 7) ? 3'd7 : 3'(k);
      checks++;
      if (c2 !== want || cnt_a[0][CW-1:0] !== '0) begin
        errors++;
        $display("FAIL cnt_sat edge%0d got ch2=%0d ch0=%0d want %0d/0",
                 k, c2, cnt_a[0][CW-1:0], want);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (cnt_a[0][2*CW +: CW] !== 3'd7) begin
      errors++;
      $display("FAIL cnt_en_hold got %0d want 7", cnt_a[0][2*CW +: CW]);
    end
    en = 1'b1; cnt_clr = 1'b1;
    step();
    checks++;
    if (cnt_a[0][2*CW +: CW] !== 3'd0 || cf_a[0] !== 4'b0100) begin
      errors++;
      $display("FAIL cnt_clr_wins got cnt=%0d cf=%b want 0/0100",
               cnt_a[0][2*CW +: CW], cf_a[0]);
    end
    cnt_clr = 1'b0;
    step();
    checks++;
    if (cnt_a[0][2*CW +: CW] !== 3'd1) begin
      errors++;
      $display("FAIL cnt_restart got %0d want 1", cnt_a[0][2*CW +: CW]);
    end
  endtask
`endif

  initial begin
    #12;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_modes();
    test_enable();
    test_toggle_reset();
`ifdef SR_CONFLICT_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
